// File: rtl/mdu_pkg.sv
// Shared MDU definitions: op codes, default latencies and result payload.
package mdu_pkg;

  localparam int unsigned MDU_OP_W = 4;
  localparam int unsigned XLEN     = 32;

  localparam logic [MDU_OP_W-1:0] OP_NONE  = 4'd0;
  localparam logic [MDU_OP_W-1:0] OP_MULT  = 4'd1;
  localparam logic [MDU_OP_W-1:0] OP_MULTU = 4'd2;
  localparam logic [MDU_OP_W-1:0] OP_DIV   = 4'd3;
  localparam logic [MDU_OP_W-1:0] OP_DIVU  = 4'd4;
  localparam logic [MDU_OP_W-1:0] OP_MFHI  = 4'd5;
  localparam logic [MDU_OP_W-1:0] OP_MFLO  = 4'd6;
  localparam logic [MDU_OP_W-1:0] OP_MTHI  = 4'd7;
  localparam logic [MDU_OP_W-1:0] OP_MTLO  = 4'd8;

  localparam int unsigned MULT_CYCLES_DEFAULT = 5;
  localparam int unsigned DIV_CYCLES_DEFAULT  = 10;

  // HI/LO pair as written back at completion.
  typedef struct packed {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
  } hilo_t;

  // True for the multi-cycle arithmetic ops that occupy the unit.
  function automatic logic is_arith(input logic [MDU_OP_W-1:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // True for divides, which use the longer latency.
  function automatic logic is_div(input logic [MDU_OP_W-1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_if.sv
// E-stage <-> MDU connection: operands/op in, busy and HI/LO/read data out.
interface e_mdu_if;

  logic                               start;
  logic [mdu_pkg::MDU_OP_W-1:0]       mdu_op;
  logic [mdu_pkg::XLEN-1:0]           a;
  logic [mdu_pkg::XLEN-1:0]           b;
  logic                               busy;
  logic [mdu_pkg::XLEN-1:0]           hi;
  logic [mdu_pkg::XLEN-1:0]           lo;
  logic [mdu_pkg::XLEN-1:0]           rd;

  modport master (
    output start, mdu_op, a, b,
    input  busy, hi, lo, rd
  );

  modport slave (
    input  start, mdu_op, a, b,
    output busy, hi, lo, rd
  );

endinterface

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: multi-cycle mult/div with HI/LO registers.
module e_mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEFAULT,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
  input logic   clk,
  input logic   reset,
  e_mdu_if.slave bus
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  hi_q;
  logic [XLEN-1:0]  lo_q;
  hilo_t            pend_q;
  logic             pend_div0_q;

  hilo_t            res;
  logic             div0;
  logic [XLEN-1:0]  rd_c;

  // Divisor substitution keeps the dividers free of x/trap cases; the
  // signed overflow case divides by 1, which yields exactly q=a, r=0.
  logic               b_zero;
  logic               div_ovf;
  logic [XLEN-1:0]    sdivisor;
  logic [XLEN-1:0]    udivisor;
  logic signed [XLEN-1:0] sq;
  logic signed [XLEN-1:0] sr;
  logic [XLEN-1:0]    uq;
  logic [XLEN-1:0]    ur;
  logic [2*XLEN-1:0]  prod_s;
  logic [2*XLEN-1:0]  prod_u;

  assign b_zero   = (bus.b == '0);
  assign div_ovf  = (bus.a == 32'h8000_0000) && (bus.b == 32'hFFFF_FFFF);
  assign sdivisor = (b_zero || div_ovf) ? XLEN'(1) : bus.b;
  assign udivisor = b_zero ? XLEN'(1) : bus.b;
  assign sq       = $signed(bus.a) / $signed(sdivisor);
  assign sr       = $signed(bus.a) % $signed(sdivisor);
  assign uq       = bus.a / udivisor;
  assign ur       = bus.a % udivisor;
  assign prod_s   = {{XLEN{bus.a[XLEN-1]}}, bus.a} * {{XLEN{bus.b[XLEN-1]}}, bus.b};
  assign prod_u   = {{XLEN{1'b0}}, bus.a} * {{XLEN{1'b0}}, bus.b};

  // Select the 64-bit result for the requested arithmetic op.
  always_comb begin
    res  = '0;
    div0 = 1'b0;
    case (bus.mdu_op)
      OP_MULT:  res = prod_s;
      OP_MULTU: res = prod_u;
      OP_DIV: begin
        res.hi = sr;
        res.lo = sq;
        div0   = b_zero;
      end
      OP_DIVU: begin
        res.hi = ur;
        res.lo = uq;
        div0   = b_zero;
      end
      default: res = '0;
    endcase
  end

  // Busy countdown, pending result latch and HI/LO architectural update.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      pend_q      <= '0;
      pend_div0_q <= 1'b0;
    end else if (busy_q) begin
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_q <= 1'b0;
        if (!pend_div0_q) begin
          hi_q <= pend_q.hi;
          lo_q <= pend_q.lo;
        end
      end
    end else begin
      if (bus.start && is_arith(bus.mdu_op)) begin
        busy_q      <= 1'b1;
        cnt_q       <= is_div(bus.mdu_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        pend_q      <= res;
        pend_div0_q <= div0;
      end
      if (bus.mdu_op == OP_MTHI) begin
        hi_q <= bus.a;
      end
      if (bus.mdu_op == OP_MTLO) begin
        lo_q <= bus.a;
      end
    end
  end

  // Read port: architectural HI/LO only, no bypass of an in-flight result.
  always_comb begin
    rd_c = '0;
    case (bus.mdu_op)
      OP_MFHI: rd_c = hi_q;
      OP_MFLO: rd_c = lo_q;
      default: rd_c = '0;
    endcase
  end

  assign bus.busy = busy_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.rd   = rd_c;

endmodule
